// File: rtl/mantis_sprite_pkg.sv
// Shared defaults and types for the Mantis sprite address generator.
package mantis_sprite_pkg;

    localparam int SPR_W       = 70;
    localparam int SPR_H       = 160;
    localparam int NUM_FRAMES  = 2;
    localparam int FRAME_HOLD  = 8;
    localparam int ADDR_W      = 15;
    localparam int FRAME_WORDS = SPR_W * SPR_H;

    typedef enum logic {
        ANIM_STOP = 1'b0,
        ANIM_RUN  = 1'b1
    } anim_state_t;

endpackage

// File: rtl/mantis_anim_fsm.sv
// Animation frame sequencer: steps frame_idx every FRAME_HOLD frame_start
// pulses while anim_en is held; evaluates only on frame_start cycles.
module mantis_anim_fsm #(
    parameter int NUM_FRAMES = mantis_sprite_pkg::NUM_FRAMES,
    parameter int FRAME_HOLD = mantis_sprite_pkg::FRAME_HOLD
) (
    input  logic                          vga_clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic                          anim_en,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_idx
);
    import mantis_sprite_pkg::*;

    localparam int FI_W = $clog2(NUM_FRAMES);
    localparam int HC_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    anim_state_t     state_q, state_d;
    logic [HC_W-1:0] hold_q, hold_d;
    logic [FI_W-1:0] frame_q, frame_d;

    // State, hold counter and frame index registers; reset wins over frame_start.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q <= ANIM_STOP;
            hold_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            frame_q <= frame_d;
        end
    end

    // Next-state logic; everything holds outside frame_start cycles.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        frame_d = frame_q;
        if (frame_start) begin
            case (state_q)
                ANIM_STOP: begin
                    hold_d  = '0;
                    frame_d = '0;
                    if (anim_en) state_d = ANIM_RUN;
                end
                ANIM_RUN: begin
                    if (!anim_en) begin
                        state_d = ANIM_STOP;
                        hold_d  = '0;
                        frame_d = '0;
                    end else if (hold_q == HC_W'(FRAME_HOLD - 1)) begin
                        hold_d  = '0;
                        frame_d = (frame_q == FI_W'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ANIM_STOP;
                    hold_d  = '0;
                    frame_d = '0;
                end
            endcase
        end
    end

    assign frame_idx = frame_q;

endmodule

// File: rtl/mantis_sprite_addr_gen.sv
// Sprite ROM address generator: two-stage pipeline from DrawX/DrawY/blank to
// rom_address/hit, with per-frame shadowed position and animation frames.
// Optional macro SPRITE_FLIP_EN enables horizontal mirroring via the flip port.
module mantis_sprite_addr_gen #(
    parameter int SPR_W      = mantis_sprite_pkg::SPR_W,
    parameter int SPR_H      = mantis_sprite_pkg::SPR_H,
    parameter int NUM_FRAMES = mantis_sprite_pkg::NUM_FRAMES,
    parameter int FRAME_HOLD = mantis_sprite_pkg::FRAME_HOLD,
    parameter int ADDR_W     = mantis_sprite_pkg::ADDR_W
) (
    input  logic                          vga_clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic                          blank,
    input  logic [9:0]                    pos_x,
    input  logic [9:0]                    pos_y,
    input  logic                          flip,
    input  logic                          anim_en,
    output logic [ADDR_W-1:0]             rom_address,
    output logic                          hit,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_idx
);
    import mantis_sprite_pkg::*;

    localparam int FRAME_SZ = SPR_W * SPR_H;

    logic [9:0] pos_x_q, pos_y_q;
`ifdef SPRITE_FLIP_EN
    logic       flip_q;
`else
    logic       unused_flip;
    assign unused_flip = flip;
`endif

    // Shadow position/flip, refreshed only at the start of vertical blank.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            pos_x_q <= '0;
            pos_y_q <= '0;
`ifdef SPRITE_FLIP_EN
            flip_q  <= 1'b0;
`endif
        end else if (frame_start) begin
            pos_x_q <= pos_x;
            pos_y_q <= pos_y;
`ifdef SPRITE_FLIP_EN
            flip_q  <= flip;
`endif
        end
    end

    logic [10:0] dx_d, dy_d, dx_q, dy_q;
    logic        in_x_d, in_y_d, in_x_q, in_y_q, vis_q;

    // Stage 1 combinational: offsets and bounds tests against the shadow position.
    always_comb begin
        dx_d   = {1'b0, DrawX} - {1'b0, pos_x_q};
        dy_d   = {1'b0, DrawY} - {1'b0, pos_y_q};
        in_x_d = (DrawX >= pos_x_q) && (dx_d < 11'(SPR_W));
        in_y_d = (DrawY >= pos_y_q) && (dy_d < 11'(SPR_H));
    end

    // Stage 1 register.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            dx_q   <= '0;
            dy_q   <= '0;
            in_x_q <= 1'b0;
            in_y_q <= 1'b0;
            vis_q  <= 1'b0;
        end else begin
            dx_q   <= dx_d;
            dy_q   <= dy_d;
            in_x_q <= in_x_d;
            in_y_q <= in_y_d;
            vis_q  <= blank;
        end
    end

    logic [10:0]       col;
    logic              hit_d, hit_q;
    logic [ADDR_W-1:0] addr_d, addr_q;

    // Stage 2 combinational: column select and constant-multiply address.
    always_comb begin
        col = dx_q;
`ifdef SPRITE_FLIP_EN
        if (flip_q) col = 11'(SPR_W - 1) - dx_q;
`endif
        hit_d  = in_x_q & in_y_q & vis_q;
        addr_d = '0;
        if (hit_d) begin
            addr_d = ADDR_W'(frame_idx) * ADDR_W'(FRAME_SZ)
                   + ADDR_W'(dy_q) * ADDR_W'(SPR_W)
                   + ADDR_W'(col);
        end
    end

    // Stage 2 register drives the outputs.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hit_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            hit_q  <= hit_d;
            addr_q <= addr_d;
        end
    end

    assign hit         = hit_q;
    assign rom_address = addr_q;

    mantis_anim_fsm #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_HOLD (FRAME_HOLD)
    ) u_anim (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .frame_start (frame_start),
        .anim_en     (anim_en),
        .frame_idx   (frame_idx)
    );

endmodule

// File: tb/tb_mantis_sprite_addr_gen.sv
// Directed self-checking bench for mantis_sprite_addr_gen (default parameters).
module tb_mantis_sprite_addr_gen;

    logic        vga_clk = 1'b0;
    logic        reset, frame_start, blank, flip, anim_en;
    logic [9:0]  DrawX, DrawY, pos_x, pos_y;
    logic [14:0] rom_address;
    logic        hit;
    logic [0:0]  frame_idx;

    int checks   = 0;
    int failures = 0;

    mantis_sprite_addr_gen dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .frame_start (frame_start),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .flip        (flip),
        .anim_en     (anim_en),
        .rom_address (rom_address),
        .hit         (hit),
        .frame_idx   (frame_idx)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic pipe();
        tick();
        tick();
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y);
        DrawX = x;
        DrawY = y;
        pipe();
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; blank = 1'b1; flip = 1'b0; anim_en = 1'b0;
        DrawX = 10'd100; DrawY = 10'd50; pos_x = 10'd100; pos_y = 10'd50;
        tick(); tick();
        chk("reset_hit", 32'(hit), 0);
        chk("reset_addr", 32'(rom_address), 0);
        chk("reset_frame", 32'(frame_idx), 0);

        // Capture pos=(100,50), flip=0
        reset = 1'b0;
        pulse();
        pix(10'd100, 10'd50);
        chk("origin_hit", 32'(hit), 1);
        chk("origin_addr", 32'(rom_address), 0);

        pix(10'd169, 10'd209);
        chk("corner_hit", 32'(hit), 1);
        chk("corner_addr", 32'(rom_address), 11199);

        pix(10'd170, 10'd209);
        chk("right_edge_hit", 32'(hit), 0);
        chk("right_edge_addr", 32'(rom_address), 0);

        // Latency: one cycle after moving into the sprite, still the old miss
        DrawX = 10'd101; DrawY = 10'd51;
        tick();
        chk("lat1_hit", 32'(hit), 0);
        tick();
        chk("lat2_hit", 32'(hit), 1);
        chk("lat2_addr", 32'(rom_address), 71);

        pix(10'd99, 10'd50);
        chk("left_edge_hit", 32'(hit), 0);
        pix(10'd100, 10'd49);
        chk("top_edge_hit", 32'(hit), 0);
        pix(10'd100, 10'd210);
        chk("bottom_edge_hit", 32'(hit), 0);

        blank = 1'b0;
        pix(10'd100, 10'd50);
        chk("blank_hit", 32'(hit), 0);
        chk("blank_addr", 32'(rom_address), 0);
        blank = 1'b1;

        // Mirroring
        flip = 1'b1;
        pulse();
        pix(10'd100, 10'd50);
`ifdef SPRITE_FLIP_EN
        chk("flip_addr", 32'(rom_address), 69);
`else
        chk("flip_addr", 32'(rom_address), 0);
`endif
        pix(10'd169, 10'd51);
`ifdef SPRITE_FLIP_EN
        chk("flip_addr2", 32'(rom_address), 70);
`else
        chk("flip_addr2", 32'(rom_address), 139);
`endif
        flip = 1'b0;
        pulse();

        // Shadow: pos_x change without frame_start has no effect
        pos_x = 10'd200;
        pix(10'd100, 10'd50);
        chk("shadow_hold_hit", 32'(hit), 1);
        chk("shadow_hold_addr", 32'(rom_address), 0);
        pulse();
        pix(10'd100, 10'd50);
        chk("shadow_new_miss", 32'(hit), 0);
        pix(10'd205, 10'd50);
        chk("shadow_new_hit", 32'(hit), 1);
        chk("shadow_new_addr", 32'(rom_address), 5);

        // Clipping at the right screen edge, no wrap to column 0
        pos_x = 10'd600;
        pulse();
        pix(10'd639, 10'd50);
        chk("clip_last_addr", 32'(rom_address), 39);
        pix(10'd0, 10'd50);
        chk("clip_nowrap_hit", 32'(hit), 0);
        pos_x = 10'd100;
        pulse();

        // Animation
        anim_en = 1'b1;
        for (int i = 1; i <= 8; i++) pulse();
        chk("anim_after8", 32'(frame_idx), 0);
        pulse();
        chk("anim_after9", 32'(frame_idx), 1);
        pix(10'd100, 10'd50);
        chk("anim_f1_addr", 32'(rom_address), 11200);
        for (int i = 0; i < 5; i++) tick();
        chk("anim_stable", 32'(frame_idx), 1);
        for (int i = 10; i <= 16; i++) pulse();
        chk("anim_after16", 32'(frame_idx), 1);
        pulse();
        chk("anim_after17", 32'(frame_idx), 0);
        for (int i = 18; i <= 25; i++) pulse();
        chk("anim_after25", 32'(frame_idx), 1);

        // anim_en=0 in RUN stops on that pulse
        anim_en = 1'b0;
        pulse();
        chk("anim_stop", 32'(frame_idx), 0);

        // Restart, reach frame 1, then reset mid-run
        anim_en = 1'b1;
        for (int i = 1; i <= 9; i++) pulse();
        chk("rerun_after9", 32'(frame_idx), 1);
        DrawX = 10'd100; DrawY = 10'd50;
        tick();
        reset = 1'b1;
        tick();
        chk("midreset_frame", 32'(frame_idx), 0);
        chk("midreset_hit", 32'(hit), 0);
        reset = 1'b0;
        // Progress fully aborted: eight pulses keep frame 0, ninth advances
        for (int i = 1; i <= 8; i++) pulse();
        chk("postreset_after8", 32'(frame_idx), 0);
        pulse();
        chk("postreset_after9", 32'(frame_idx), 1);

        // reset wins over a simultaneous frame_start
        pos_x = 10'd300; pos_y = 10'd300;
        reset = 1'b1; frame_start = 1'b1;
        tick();
        reset = 1'b0; frame_start = 1'b0;
        chk("rst_fs_frame", 32'(frame_idx), 0);
        pix(10'd0, 10'd0);
        chk("rst_fs_shadow_hit", 32'(hit), 1);
        chk("rst_fs_shadow_addr", 32'(rom_address), 0);
        pix(10'd300, 10'd300);
        chk("rst_fs_old_pos_miss", 32'(hit), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
